// File: rtl/cmap_ctrl.sv
// Palette controller: maps 8-bit pixel magnitudes through a host-writable,
// multi-palette RGB RAM. Palette switches take effect only at frame starts.
module cmap_ctrl #(
    parameter int LGMAPS   = 2,
    parameter int LGSTARVE = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_sel_valid,
    input  logic [LGMAPS-1:0] i_sel_map,
    output logic [LGMAPS-1:0] o_active_map,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [LGMAPS-1:0] i_wr_map,
    input  logic [7:0]        i_wr_idx,
    input  logic [23:0]       i_wr_rgb,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [7:0]        i_pixel,
    input  logic              i_sof,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_r,
    output logic [7:0]        o_g,
    output logic [7:0]        o_b,
    output logic              o_sof
);

    localparam int NMAPS = 2**LGMAPS;
    localparam int AW    = LGMAPS + 8;

    logic [23:0]         mem [NMAPS*256];

    logic                s1_valid_q, s1_sof_q;
    logic [23:0]         s1_rgb_q;
    logic                out_valid_q, out_sof_q;
    logic [23:0]         out_rgb_q;
    logic [LGMAPS-1:0]   active_map_q, pending_map_q;
    logic                pending_q;
    logic [LGSTARVE-1:0] starve_q, starve_d;

    logic                adv, grant_host, pix_slot, pix_accept, wr_en, sof_switch;
    logic [LGMAPS-1:0]   map_for_pixel;
    logic [AW-1:0]       rd_addr, wr_addr;

    assign adv           = !out_valid_q || i_ready;
    assign grant_host    = (starve_q == '1);
    assign pix_slot      = i_valid && adv && !grant_host;
    assign o_ready       = adv && !grant_host;
    assign o_wr_ready    = i_wr_valid && (!(i_valid && adv) || grant_host);
    assign wr_en         = o_wr_ready;
    assign pix_accept    = i_valid && o_ready;
    assign sof_switch    = pix_accept && i_sof && pending_q;
    assign map_for_pixel = (i_sof && pending_q) ? pending_map_q : active_map_q;
    assign rd_addr       = {map_for_pixel, i_pixel};
    assign wr_addr       = {i_wr_map, i_wr_idx};

    // The starvation count only grows while a write is being refused.
    always_comb begin
        starve_d = starve_q;
        if (!i_wr_valid || o_wr_ready) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Single RAM port: a write and a read never share a cycle.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= i_wr_rgb;
        end else if (adv) begin
            s1_rgb_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_sof_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_rgb_q     <= '0;
            active_map_q  <= '0;
            pending_map_q <= '0;
            pending_q     <= 1'b0;
            starve_q      <= '0;
        end else begin
            starve_q <= starve_d;
            if (adv) begin
                s1_valid_q  <= pix_slot;
                s1_sof_q    <= pix_slot && i_sof;
                out_valid_q <= s1_valid_q;
                out_sof_q   <= s1_sof_q;
                out_rgb_q   <= s1_rgb_q;
            end
            if (sof_switch) begin
                active_map_q <= pending_map_q;
                pending_q    <= 1'b0;
            end
            // A request arriving with the switching sof pixel waits for the next frame.
            if (i_sel_valid) begin
                pending_map_q <= i_sel_map;
                pending_q     <= 1'b1;
            end
        end
    end

    assign o_valid      = out_valid_q;
    assign o_sof        = out_sof_q;
    assign o_r          = out_rgb_q[23:16];
    assign o_g          = out_rgb_q[15:8];
    assign o_b          = out_rgb_q[7:0];
    assign o_active_map = active_map_q;

endmodule

// File: tb/tb_cmap_ctrl.sv
// Directed self-checking bench for cmap_ctrl: reset, frame-boundary palette
// switching, write/read hazard, palette load, starvation, backpressure, mid-run reset.
module tb_cmap_ctrl;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_sel_valid;
    logic [1:0]  i_sel_map;
    logic [1:0]  o_active_map;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [1:0]  i_wr_map;
    logic [7:0]  i_wr_idx;
    logic [23:0] i_wr_rgb;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_pixel;
    logic        i_sof;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_sof;

    int checks   = 0;
    int failures = 0;

    logic [23:0] pal [1024];
    logic [24:0] exp_q [$];

    always #5 clk = ~clk;

    cmap_ctrl #(.LGMAPS(2), .LGSTARVE(4)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_sel_valid(i_sel_valid), .i_sel_map(i_sel_map), .o_active_map(o_active_map),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_map(i_wr_map),
        .i_wr_idx(i_wr_idx), .i_wr_rgb(i_wr_rgb),
        .i_valid(i_valid), .o_ready(o_ready), .i_pixel(i_pixel), .i_sof(i_sof),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_sof(o_sof)
    );

    function automatic logic [23:0] map1_rgb(input logic [7:0] k);
        return {k, 8'd255 - k, k ^ 8'h55};
    endfunction

    task automatic idle_inputs;
        i_sel_valid = 1'b0; i_sel_map = '0;
        i_wr_valid = 1'b0; i_wr_map = '0; i_wr_idx = '0; i_wr_rgb = '0;
        i_valid = 1'b0; i_pixel = '0; i_sof = 1'b0; i_ready = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        i_reset_n = 1'b0;
        tick(); tick();
        i_reset_n = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_sof !== 1'b0) begin failures++; $display("FAIL reset_o_sof got=%b exp=0", o_sof); end
        checks++; if ({o_r, o_g, o_b} !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=000000", {o_r, o_g, o_b}); end
        checks++; if (o_active_map !== 2'd0) begin failures++; $display("FAIL reset_active_map got=%0d exp=0", o_active_map); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
        checks++; if (o_wr_ready !== 1'b0) begin failures++; $display("FAIL reset_o_wr_ready got=%b exp=0", o_wr_ready); end
    endtask

    task automatic test_switch;
        logic [7:0] b;
        int         m;
        logic [9:0] a;
        for (int mi = 0; mi < 2; mi++) begin
            for (int i = 0; i < 16; i++) begin
                tick(); idle_inputs();
                b = 8'(i);
                i_wr_valid = 1'b1;
                i_wr_map   = (mi == 0) ? 2'd0 : 2'd2;
                i_wr_idx   = b;
                i_wr_rgb   = (mi == 0) ? {8'h10 + b, 8'h20, b} : {8'hC0, b, 8'h33};
                #1;
                checks++; if (o_wr_ready !== 1'b1) begin failures++; $display("FAIL switch_load_wr_ready got=%b exp=1", o_wr_ready); end
                pal[{i_wr_map, b}] = i_wr_rgb;
            end
        end
        tick(); idle_inputs();
        for (int c = 0; c < 34; c++) begin
            tick(); idle_inputs();
            if (c < 32) begin
                i_valid = 1'b1;
                i_pixel = 8'(c % 16);
                i_sof   = (c % 16 == 0);
            end
            if (c == 5) begin
                i_sel_valid = 1'b1;
                i_sel_map   = 2'd2;
            end
            #1;
            checks++;
            if (o_active_map !== ((c >= 17) ? 2'd2 : 2'd0)) begin
                failures++; $display("FAIL switch_active_map c=%0d got=%0d exp=%0d", c, o_active_map, (c >= 17) ? 2 : 0);
            end
            if (c >= 2) begin
                m = ((c - 2) < 16) ? 0 : 2;
                a = {2'(m), 8'((c - 2) % 16)};
                checks++;
                if (o_valid !== 1'b1 || {o_r, o_g, o_b} !== pal[a] || o_sof !== ((c - 2) % 16 == 0)) begin
                    failures++; $display("FAIL switch_pixel c=%0d got v=%b rgb=%h sof=%b exp v=1 rgb=%h sof=%b",
                                         c, o_valid, {o_r, o_g, o_b}, o_sof, pal[a], (c - 2) % 16 == 0);
                end
            end else begin
                checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL switch_latency c=%0d got v=%b exp=0", c, o_valid); end
            end
        end
    endtask

    task automatic test_hazard;
        tick(); idle_inputs();
        i_sel_valid = 1'b1; i_sel_map = 2'd0;
        i_wr_valid = 1'b1; i_wr_map = 2'd0; i_wr_idx = 8'd7; i_wr_rgb = 24'hABCDEF;
        #1;
        checks++; if (o_wr_ready !== 1'b1) begin failures++; $display("FAIL hazard_wr_ready got=%b exp=1", o_wr_ready); end
        pal[{2'd0, 8'd7}] = 24'hABCDEF;
        tick(); idle_inputs();
        i_valid = 1'b1; i_pixel = 8'd7; i_sof = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL hazard_o_ready got=%b exp=1", o_ready); end
        tick(); idle_inputs(); #1;
        tick(); idle_inputs(); #1;
        checks++;
        if (o_valid !== 1'b1 || o_r !== 8'hAB || o_g !== 8'hCD || o_b !== 8'hEF || o_sof !== 1'b1) begin
            failures++; $display("FAIL hazard_pixel got v=%b rgb=%h sof=%b exp v=1 rgb=abcdef sof=1", o_valid, {o_r, o_g, o_b}, o_sof);
        end
        checks++; if (o_active_map !== 2'd0) begin failures++; $display("FAIL hazard_active_map got=%0d exp=0", o_active_map); end
    endtask

    task automatic test_load_map;
        logic [7:0]  k;
        logic [23:0] e;
        for (int i = 0; i < 256; i++) begin
            tick(); idle_inputs();
            k = 8'(i);
            i_wr_valid = 1'b1; i_wr_map = 2'd1; i_wr_idx = k; i_wr_rgb = map1_rgb(k);
            #1;
            checks++; if (o_wr_ready !== 1'b1) begin failures++; $display("FAIL load_wr_ready idx=%0d got=%b exp=1", i, o_wr_ready); end
            pal[{2'd1, k}] = map1_rgb(k);
        end
        tick(); idle_inputs();
        i_sel_valid = 1'b1; i_sel_map = 2'd1;
        #1;
        for (int c = 0; c < 258; c++) begin
            tick(); idle_inputs();
            if (c < 256) begin
                i_valid = 1'b1; i_pixel = 8'(c); i_sof = (c == 0);
            end
            #1;
            if (c < 256) begin
                checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL load_o_ready c=%0d got=%b exp=1", c, o_ready); end
            end
            if (c >= 2) begin
                e = map1_rgb(8'(c - 2));
                checks++;
                if (o_valid !== 1'b1 || {o_r, o_g, o_b} !== e || o_sof !== (c == 2)) begin
                    failures++; $display("FAIL load_pixel c=%0d got v=%b rgb=%h sof=%b exp v=1 rgb=%h sof=%b",
                                         c, o_valid, {o_r, o_g, o_b}, o_sof, e, c == 2);
                end
            end else begin
                checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL load_latency c=%0d got v=%b exp=0", c, o_valid); end
            end
        end
        tick(); idle_inputs(); #1;
        checks++; if (o_active_map !== 2'd1) begin failures++; $display("FAIL load_active_map got=%0d exp=1", o_active_map); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL load_drained got v=%b exp=0", o_valid); end
    endtask

    task automatic test_starvation;
        logic [7:0]  next_px = 8'd0;
        int          accepted = 0;
        int          emitted  = 0;
        logic [24:0] e;
        exp_q.delete();
        for (int c = 0; c < 44; c++) begin
            tick(); idle_inputs();
            if (c < 40) begin
                i_valid = 1'b1; i_pixel = next_px;
            end
            if (c <= 15) begin
                i_wr_valid = 1'b1; i_wr_map = 2'd3; i_wr_idx = 8'd0; i_wr_rgb = 24'h123456;
            end
            #1;
            if (c < 40) begin
                checks++;
                if (o_ready !== (c != 15)) begin failures++; $display("FAIL starve_o_ready c=%0d got=%b exp=%b", c, o_ready, c != 15); end
            end
            if (c <= 15) begin
                checks++;
                if (o_wr_ready !== (c == 15)) begin failures++; $display("FAIL starve_wr_ready c=%0d got=%b exp=%b", c, o_wr_ready, c == 15); end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back({1'b0, map1_rgb(next_px)});
                next_px++;
                accepted++;
            end
            if (o_valid && i_ready) begin
                emitted++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL starve_extra_output got rgb=%h exp none", {o_r, o_g, o_b});
                end else begin
                    e = exp_q.pop_front();
                    if ({o_sof, o_r, o_g, o_b} !== e) begin
                        failures++; $display("FAIL starve_pixel got=%h exp=%h", {o_sof, o_r, o_g, o_b}, e);
                    end
                end
            end
        end
        pal[{2'd3, 8'd0}] = 24'h123456;
        checks++; if (accepted !== 39) begin failures++; $display("FAIL starve_accepted got=%0d exp=39", accepted); end
        checks++; if (emitted !== 39) begin failures++; $display("FAIL starve_emitted got=%0d exp=39", emitted); end
    endtask

    task automatic test_backpressure;
        int          sent = 0;
        int          recv = 0;
        int          cyc  = 0;
        logic        prev_hold = 1'b0;
        logic [24:0] prev_out  = '0;
        logic [24:0] e;
        exp_q.delete();
        while ((sent < 1000 || exp_q.size() != 0 || o_valid) && cyc < 8000) begin
            tick(); idle_inputs();
            i_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            i_pixel = 8'($urandom_range(0, 255));
            i_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_hold) begin
                checks++;
                if (o_valid !== 1'b1 || {o_sof, o_r, o_g, o_b} !== prev_out) begin
                    failures++; $display("FAIL bp_stable got v=%b out=%h exp v=1 out=%h", o_valid, {o_sof, o_r, o_g, o_b}, prev_out);
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back({1'b0, map1_rgb(i_pixel)});
                sent++;
            end
            if (o_valid && i_ready) begin
                recv++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra_output got rgb=%h exp none", {o_r, o_g, o_b});
                end else begin
                    e = exp_q.pop_front();
                    if ({o_sof, o_r, o_g, o_b} !== e) begin
                        failures++; $display("FAIL bp_pixel n=%0d got=%h exp=%h", recv, {o_sof, o_r, o_g, o_b}, e);
                    end
                end
            end
            prev_hold = o_valid && !i_ready;
            prev_out  = {o_sof, o_r, o_g, o_b};
            cyc++;
        end
        checks++; if (cyc >= 8000) begin failures++; $display("FAIL bp_timeout got cycles=%0d exp <8000", cyc); end
        checks++; if (recv !== 1000) begin failures++; $display("FAIL bp_count got=%0d exp=1000", recv); end
    endtask

    task automatic test_reset_mid;
        tick(); idle_inputs();
        i_sel_valid = 1'b1; i_sel_map = 2'd2;
        #1;
        tick(); idle_inputs(); i_valid = 1'b1; i_pixel = 8'd10; #1;
        tick(); idle_inputs(); i_valid = 1'b1; i_pixel = 8'd11; #1;
        tick(); idle_inputs(); i_reset_n = 1'b0; #1;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL rstmid_inflight got v=%b exp=1", o_valid); end
        tick(); idle_inputs(); i_reset_n = 1'b1; #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_active_map !== 2'd0) begin failures++; $display("FAIL rstmid_active_map got=%0d exp=0", o_active_map); end
        for (int c = 0; c < 4; c++) begin
            tick(); idle_inputs(); #1;
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale c=%0d got v=%b exp=0", c, o_valid); end
        end
        tick(); idle_inputs(); i_valid = 1'b1; i_pixel = 8'd3; i_sof = 1'b1; #1;
        tick(); idle_inputs(); #1;
        tick(); idle_inputs(); #1;
        checks++;
        if (o_valid !== 1'b1 || {o_r, o_g, o_b} !== pal[{2'd0, 8'd3}] || o_sof !== 1'b1) begin
            failures++; $display("FAIL rstmid_sof_pixel got v=%b rgb=%h sof=%b exp v=1 rgb=%h sof=1",
                                 o_valid, {o_r, o_g, o_b}, o_sof, pal[{2'd0, 8'd3}]);
        end
        checks++; if (o_active_map !== 2'd0) begin failures++; $display("FAIL rstmid_no_switch got=%0d exp=0", o_active_map); end
    endtask

    initial begin
        i_reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_switch();
        test_hazard();
        test_load_map();
        test_starvation();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
